// File: rtl/alu_hs_pipe.sv
// alu_hs_pipe: valid/ready ALU with a one-entry result register and backpressure.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for opcode 10.
module alu_hs_pipe #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned OPWIDTH = 4,
  parameter int unsigned SHW     = $clog2(DWIDTH)
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [DWIDTH-1:0]  A,
  input  logic [DWIDTH-1:0]  B,
  input  logic [OPWIDTH-1:0] S,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [DWIDTH-1:0]  Y,
  output logic               C,
  output logic               V,
  output logic               Z,
  output logic               BUSY
);

  localparam int unsigned MSB = DWIDTH - 1;
  localparam int unsigned CW  = SHW;

  localparam logic [OPWIDTH-1:0] OP_ADD  = OPWIDTH'(0);
  localparam logic [OPWIDTH-1:0] OP_INCA = OPWIDTH'(1);
  localparam logic [OPWIDTH-1:0] OP_INCB = OPWIDTH'(2);
  localparam logic [OPWIDTH-1:0] OP_SUB  = OPWIDTH'(3);
  localparam logic [OPWIDTH-1:0] OP_CMP  = OPWIDTH'(4);
  localparam logic [OPWIDTH-1:0] OP_ROL  = OPWIDTH'(5);
  localparam logic [OPWIDTH-1:0] OP_ROR  = OPWIDTH'(6);
  localparam logic [OPWIDTH-1:0] OP_CLRY = OPWIDTH'(7);
  localparam logic [OPWIDTH-1:0] OP_DECA = OPWIDTH'(8);
  localparam logic [OPWIDTH-1:0] OP_DECB = OPWIDTH'(9);
  localparam logic [OPWIDTH-1:0] OP_MUL  = OPWIDTH'(10);
  localparam logic [OPWIDTH-1:0] OP_CPLA = OPWIDTH'(11);
  localparam logic [OPWIDTH-1:0] OP_AND  = OPWIDTH'(12);
  localparam logic [OPWIDTH-1:0] OP_OR   = OPWIDTH'(13);
  localparam logic [OPWIDTH-1:0] OP_XOR  = OPWIDTH'(14);
  localparam logic [OPWIDTH-1:0] OP_CPLB = OPWIDTH'(15);

  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] y_q, y_d;
  logic              c_q, c_d, v_q, v_d, z_q, z_d;

  logic accept, pop, is_mul, mul_done;

  logic [DWIDTH-1:0]   as_x, as_y;
  logic                as_sub, as_ovf;
  logic [DWIDTH:0]     as_sum;
  logic [2*DWIDTH-1:0] rol_w, ror_w;
  logic [DWIDTH-1:0]   r_y;
  logic                r_c, r_v, r_z, r_keep;

  assign pop       = out_valid_q && OUT_READY;
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = out_valid_q;
  assign Y         = y_q;
  assign C         = c_q;
  assign V         = v_q;
  assign Z         = z_q;

  // Shared adder/subtractor operand selection for the arithmetic opcodes.
  always_comb begin
    as_x   = A;
    as_y   = B;
    as_sub = 1'b0;
    case (S)
      OP_INCA: as_y = DWIDTH'(1);
      OP_INCB: begin as_x = B; as_y = DWIDTH'(1); end
      OP_SUB, OP_CMP: as_sub = 1'b1;
      OP_DECA: begin as_y = DWIDTH'(1); as_sub = 1'b1; end
      OP_DECB: begin as_x = B; as_y = DWIDTH'(1); as_sub = 1'b1; end
      default: ;
    endcase
    as_sum = as_sub ? ({1'b0, as_x} - {1'b0, as_y}) : ({1'b0, as_x} + {1'b0, as_y});
    as_ovf = as_sub ? ((as_x[MSB] != as_y[MSB]) && (as_sum[MSB] != as_x[MSB]))
                    : ((as_x[MSB] == as_y[MSB]) && (as_sum[MSB] != as_x[MSB]));
  end

  // Rotates via a doubled operand so amount 0 falls out naturally.
  assign rol_w = {A, A} << B[SHW-1:0];
  assign ror_w = {A, A} >> B[SHW-1:0];

  // Single-cycle result and flags; CMP only updates flags.
  always_comb begin
    r_y    = '0;
    r_c    = 1'b0;
    r_v    = 1'b0;
    r_keep = 1'b0;
    case (S)
      OP_ADD, OP_INCA, OP_INCB, OP_SUB, OP_DECA, OP_DECB: begin
        r_y = as_sum[DWIDTH-1:0];
        r_c = as_sum[DWIDTH];
        r_v = as_ovf;
      end
      OP_CMP: begin
        r_keep = 1'b1;
        r_c    = as_sum[DWIDTH];
        r_v    = as_ovf;
      end
      OP_ROL:  r_y = rol_w[2*DWIDTH-1:DWIDTH];
      OP_ROR:  r_y = ror_w[DWIDTH-1:0];
      OP_CPLA: r_y = ~A;
      OP_CPLB: r_y = ~B;
      OP_AND:  r_y = A & B;
      OP_OR:   r_y = A | B;
      OP_XOR:  r_y = A ^ B;
      OP_CLRY, OP_MUL: ;
      default: ;
    endcase
    r_z = r_keep ? (as_sum[DWIDTH-1:0] == '0) : (r_y == '0);
  end

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [2*DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH:0]     step_sum;

  assign is_mul = (S == OP_MUL);
  assign BUSY   = (state_q == ST_MUL);
  // CLR gating keeps the handshake honest while reset owns the block.
  assign IN_READY = (state_q == ST_IDLE) && (!out_valid_q || OUT_READY) && !CLR;

  // Multiplier FSM: add multiplicand to the high half, shift right, LSB-first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    mul_done = 1'b0;
    step_sum = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (mb_q[0] ? {1'b0, ma_q} : '0);
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_d = ST_MUL;
          cnt_d   = CW'(DWIDTH - 1);
          ma_d    = A;
          mb_d    = B;
          acc_d   = '0;
        end
      end
      ST_MUL: begin
        acc_d = {step_sum, acc_q[DWIDTH-1:1]};
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          mul_done = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign BUSY     = 1'b0;
  assign IN_READY = (!out_valid_q || OUT_READY) && !CLR;
`endif

  // Output register: pop clears, single-cycle accept or MUL completion loads.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    if (pop) out_valid_d = 1'b0;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      if (!r_keep) y_d = r_y;
      c_d = r_c;
      v_d = r_v;
      z_d = r_z;
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      out_valid_d = 1'b1;
      y_d         = acc_d[DWIDTH-1:0];
      c_d         = 1'b0;
      v_d         = (acc_d[2*DWIDTH-1:DWIDTH] != '0);
      z_d         = (acc_d[DWIDTH-1:0] == '0);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      c_q         <= c_d;
      v_q         <= v_d;
      z_q         <= z_d;
    end
  end

endmodule

// File: tb/tb_alu_hs_pipe.sv
// tb_alu_hs_pipe: directed + scoreboard bench for alu_hs_pipe at DWIDTH=8.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_hs_pipe;

  localparam int unsigned DW = 8;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd3, OP_CMP = 4'd4,
                         OP_ROL = 4'd5, OP_ROR = 4'd6, OP_MUL = 4'd10;

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       v;
    logic       z;
  } res_t;

  logic          CLK = 1'b0;
  logic          CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY, C, V, Z, BUSY;
  logic [DW-1:0] A, B, Y;
  logic [3:0]    S;

  res_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pushes = 0;
  int         pops   = 0;
  int         stalls = 0;
  logic [7:0] model_y = 8'h00;

  always #5 CLK = ~CLK;

  alu_hs_pipe #(.DWIDTH(8), .OPWIDTH(4), .SHW(3)) dut (
    .CLK(CLK), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .S(S), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .C(C), .V(V), .Z(Z), .BUSY(BUSY)
  );

  function automatic logic [31:0] pk(input logic [7:0] y, input logic c, v, z);
    return 32'({y, c, v, z});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Independent reference: integer arithmetic, bit-by-bit rotates.
  function automatic res_t model(input logic [7:0] a, b, input logic [3:0] s,
                                 input logic [7:0] prev);
    res_t r;
    int x, y, sx, sy, full, sfull;
    logic [7:0] t;
    bit arith, sub;
    r = '0;
    x = 32'(a); y = 32'(b); sx = 32'($signed(a)); sy = 32'($signed(b));
    arith = 1'b1; sub = 1'b0;
    case (s)
      4'd0: ;
      4'd1: begin y = 1; sy = 1; end
      4'd2: begin x = 32'(b); sx = 32'($signed(b)); y = 1; sy = 1; end
      4'd3, 4'd4: sub = 1'b1;
      4'd8: begin y = 1; sy = 1; sub = 1'b1; end
      4'd9: begin x = 32'(b); sx = 32'($signed(b)); y = 1; sy = 1; sub = 1'b1; end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      if (sub) begin full = x - y; sfull = sx - sy; r.c = (x < y); end
      else     begin full = x + y; sfull = sx + sy; r.c = (full > 255); end
      r.y = 8'(full);
      r.v = (sfull > 127) || (sfull < -128);
    end else begin
      case (s)
        4'd5: begin t = a; for (int i = 0; i < int'(b[2:0]); i++) t = {t[6:0], t[7]}; r.y = t; end
        4'd6: begin t = a; for (int i = 0; i < int'(b[2:0]); i++) t = {t[0], t[7:1]}; r.y = t; end
`ifdef ALU_MUL_EN
        4'd10: begin full = x * y; r.y = 8'(full); r.v = (full > 255); end
`endif
        4'd11: r.y = ~a;
        4'd12: r.y = a & b;
        4'd13: r.y = a | b;
        4'd14: r.y = a ^ b;
        4'd15: r.y = ~b;
        default: r.y = 8'h00;
      endcase
    end
    r.z = (r.y == 8'h00);
    if (s == 4'd4) r.y = prev;
    return r;
  endfunction

  // Scoreboard monitor: a pop happens at the next rising edge.
  always @(negedge CLK) begin
    if (!CLR && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out", 32'(OUT_VALID), 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        pops++;
        chk("sb_result", pk(Y, C, V, Z), 32'(e));
      end
    end
  end

  task automatic send(input logic [7:0] a, b, input logic [3:0] s, input bit push);
    int n = 0;
    res_t e;
    IN_VALID = 1'b1; A = a; B = b; S = s;
    #1;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1; n++; stalls++;
    end
    chk("accept_ready", 32'(IN_READY), 32'd1);
    if (push) begin
      e = model(a, b, s, model_y);
      model_y = e.y;
      exp_q.push_back(e);
      pushes++;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset();
    CLR = 1'b1; IN_VALID = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      chk("rst_in_ready", 32'(IN_READY), 32'd0);
    end
    chk("rst_outputs", pk(Y, C, V, Z), pk(8'h00, 1'b0, 1'b0, 1'b1));
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    CLR = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("post_rst_ready", 32'(IN_READY), 32'd1);
    model_y = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, st0;
    CLR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; A = '0; B = '0; S = '0;
    do_reset();

    send(8'h7F, 8'h01, OP_ADD, 1'b1);
    chk("add_ovf", pk(Y, C, V, Z), pk(8'h80, 1'b0, 1'b1, 1'b0));
    chk("add_lat1", 32'(OUT_VALID), 32'd1);
    send(8'hFF, 8'h01, OP_ADD, 1'b1);
    chk("add_carry", pk(Y, C, V, Z), pk(8'h00, 1'b1, 1'b0, 1'b1));

    send(8'h05, 8'h07, OP_SUB, 1'b1);
    chk("sub_borrow", pk(Y, C, V, Z), pk(8'hFE, 1'b1, 1'b0, 1'b0));
    send(8'h33, 8'h33, OP_CMP, 1'b1);
    chk("cmp_eq", pk(Y, C, V, Z), pk(8'hFE, 1'b0, 1'b0, 1'b1));

    send(8'h81, 8'h03, OP_ROL, 1'b1);
    chk("rol3", 32'(Y), 32'h0C);
    send(8'h81, 8'h03, OP_ROR, 1'b1);
    chk("ror3", 32'(Y), 32'h30);
    send(8'h81, 8'h08, OP_ROL, 1'b1);
    chk("rol0", 32'(Y), 32'h81);

`ifdef ALU_MUL_EN
    send(8'h10, 8'h20, OP_MUL, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", 32'({BUSY, IN_READY, OUT_VALID}), 32'b100);
      @(posedge CLK); #1;
    end
    chk("mul_done_valid", 32'({BUSY, OUT_VALID}), 32'b01);
    chk("mul_10x20", pk(Y, C, V, Z), pk(8'h00, 1'b0, 1'b1, 1'b1));
    send(8'h0C, 8'h0B, OP_MUL, 1'b1);
    n = 0;
    while (!OUT_VALID && n < 20) begin @(posedge CLK); #1; n++; end
    chk("mul_latency", 32'(n), 32'd8);
    chk("mul_0cx0b", pk(Y, C, V, Z), pk(8'h84, 1'b0, 1'b0, 1'b0));
    idle(2);
    send(8'h37, 8'h5A, OP_MUL, 1'b0);
    idle(3);
    chk("abort_busy_before", 32'(BUSY), 32'd1);
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    model_y = 8'h00;
    chk("abort_busy", 32'(BUSY), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_out", 32'(OUT_VALID), 32'd0);
      @(posedge CLK); #1;
    end
`else
    send(8'h12, 8'h34, OP_MUL, 1'b1);
    chk("mul_disabled", pk(Y, C, V, Z), pk(8'h00, 1'b0, 1'b0, 1'b1));
    chk("mul_disabled_busy", 32'(BUSY), 32'd0);
`endif

    for (int i = 0; i < 24; i++)
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
    idle(2);

    // Backpressure: one accept, then hold until the consumer frees the slot.
    send(8'h01, 8'h02, OP_ADD, 1'b1);
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; A = 8'h10; B = 8'h20; S = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold", 32'({IN_READY, OUT_VALID, Y}), 32'({1'b0, 1'b1, 8'h03}));
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    st0 = stalls;
    send(8'h10, 8'h20, OP_ADD, 1'b1);
    for (int i = 0; i < 6; i++) send(8'(i * 37), 8'(i + 1), OP_ADD, 1'b1);
    chk("bp_back_to_back", 32'(stalls - st0), 32'd0);
    idle(4);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("sb_count", 32'(pops), 32'(pushes));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
